sub16_serial: RTL and testbench



---
 rtl/sub16_serial.sv | 101 ++++++++++
 tb/tb_sub16_serial.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/sub16_serial.sv
// sub16_serial: bit-serial a - b, LSB first, one full-adder step per clock.
// Define SUB16_SERIAL_OVF_EN to add the signed-overflow output ovf.
module sub16_serial #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             start,
  input  logic [0:WIDTH-1] a,
  input  logic [0:WIDTH-1] b,
  output logic             busy,
  output logic             done,
  output logic [0:WIDTH-1] out,
`ifdef SUB16_SERIAL_OVF_EN
  output logic             ovf,
`endif
  output logic             borrow
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [0:WIDTH-1] sa_q, sa_d, sb_q, sb_d, sr_q, sr_d, out_q, out_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic carry_q, carry_d, borrow_q, borrow_d, sum, cout, nb;
`ifdef SUB16_SERIAL_OVF_EN
  logic ovf_q, ovf_d;
  assign ovf = ovf_q;
`endif
  assign busy   = state_q == RUN;
  assign done   = state_q == DONE;
  assign out    = out_q;
  assign borrow = borrow_q;
  // a + ~b + 1: carry is preset to 1 on load
  always_comb begin
    nb       = ~sb_q[WIDTH-1];
    sum      = sa_q[WIDTH-1] ^ nb ^ carry_q;
    cout     = (sa_q[WIDTH-1] & nb) | (sa_q[WIDTH-1] & carry_q) | (nb & carry_q);
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    sr_d     = sr_q;
    out_d    = out_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    borrow_d = borrow_q;
`ifdef SUB16_SERIAL_OVF_EN
    ovf_d    = ovf_q;
`endif
    if (start && state_q != RUN) begin
      state_d = RUN;
      sa_d    = a;
      sb_d    = b;
      sr_d    = '0;
      carry_d = 1'b1;
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      sa_d    = {1'b0, sa_q[0:WIDTH-2]};
      sb_d    = {1'b0, sb_q[0:WIDTH-2]};
      sr_d    = {sum, sr_q[0:WIDTH-2]};
      carry_d = cout;
      cnt_d   = cnt_q + CW'(1);
      if (cnt_q == CW'(WIDTH - 1)) begin
        state_d  = DONE;
        out_d    = sr_d;
        borrow_d = ~cout;
`ifdef SUB16_SERIAL_OVF_EN
        ovf_d    = carry_q ^ cout;
`endif
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      sr_q     <= '0;
      out_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
`ifdef SUB16_SERIAL_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      sr_q     <= sr_d;
      out_q    <= out_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
`ifdef SUB16_SERIAL_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end
endmodule

// File: tb/tb_sub16_serial.sv
// tb_sub16_serial: directed and random checks of sub16_serial against an arithmetic model.
module tb_sub16_serial;
  logic clock = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [0:15] a = '0, b = '0, out;
  logic busy, done, borrow;
  int n_tests = 0, n_fail = 0;
`ifdef SUB16_SERIAL_OVF_EN
  logic ovf;
`endif

  sub16_serial #(.WIDTH(16)) dut (
    .clock(clock), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .out(out),
`ifdef SUB16_SERIAL_OVF_EN
    .ovf(ovf),
`endif
    .borrow(borrow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_result(input string tag, input logic [15:0] x, input logic [15:0] y);
    int d;
    d = int'($signed(x)) - int'($signed(y));
    check({tag, "_out"}, 32'(out), (32'(x) - 32'(y)) & 32'hFFFF);
    check({tag, "_borrow"}, 32'(borrow), 32'(x < y));
`ifdef SUB16_SERIAL_OVF_EN
    check({tag, "_ovf"}, 32'(ovf), 32'(d > 32767 || d < -32768));
`else
    if (d > 100000) $display("unreachable %0d", d);
`endif
  endtask

  task automatic wait_done(input int from, output int n);
    n = from;
    while (!done && n < 40) begin
      @(negedge clock);
      n++;
    end
  endtask

  // Called at a negedge with the DUT idle or in DONE.
  task automatic run_op(input string tag, input logic [15:0] x, input logic [15:0] y);
    logic [15:0] prev;
    int n;
    prev  = out;
    a     = x;
    b     = y;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    a     = ~x;
    b     = ~y;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    repeat (8) @(negedge clock);
    check({tag, "_hold"}, 32'(out), 32'(prev));
    wait_done(8, n);
    check({tag, "_lat"}, 32'(n), 32'd16);
    check({tag, "_busy_lo"}, 32'(busy), 32'd0);
    check_result(tag, x, y);
  endtask

  initial begin
    int n;
    logic [15:0] rx, ry;
    repeat (2) @(negedge clock);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_out", 32'(out), 32'd0);
    check("rst_borrow", 32'(borrow), 32'd0);
    rst_n = 1'b1;
    @(negedge clock);
    run_op("zero", 16'h0000, 16'h0000);
    @(negedge clock);
    check("done_pulse", 32'(done), 32'd0);
    run_op("wrap", 16'h0000, 16'hFFFF);
    run_op("eq", 16'hFFFF, 16'hFFFF);
    // back-to-back with start held high through DONE
    a = 16'hAAAA; b = 16'h5555; start = 1'b1;
    @(negedge clock);
    a = 16'h1234; b = 16'h9876;
    wait_done(0, n);
    check("b2b1_lat", 32'(n), 32'd16);
    check_result("b2b1", 16'hAAAA, 16'h5555);
    @(negedge clock);
    start = 1'b0;
    check("b2b_busy", 32'(busy), 32'd1);
    wait_done(0, n);
    check("b2b2_gap", 32'(n + 1), 32'd17);
    check_result("b2b2", 16'h1234, 16'h9876);
    run_op("minneg", 16'h8000, 16'h0001);
    run_op("mix", 16'h3CC3, 16'h0FF0);
    // a second start while busy must be ignored
    @(negedge clock);
    a = 16'h0005; b = 16'h0003; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    a = 16'hFFFF; b = 16'h0000; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done(5, n);
    check("ign_lat", 32'(n), 32'd16);
    check_result("ign", 16'h0005, 16'h0003);
    // asynchronous reset mid-operation
    @(negedge clock);
    a = 16'h7777; b = 16'h1111; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (7) @(negedge clock);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_out", 32'(out), 32'd0);
    check("arst_borrow", 32'(borrow), 32'd0);
    n = 0;
    repeat (20) begin
      @(negedge clock);
      n += int'(done);
    end
    check("arst_nodone", 32'(n), 32'd0);
    rst_n = 1'b1;
    @(negedge clock);
    run_op("post_rst", 16'h0010, 16'h0001);
    for (int i = 0; i < 20; i++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      run_op("rand", rx, ry);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
